// File: rtl/tft_timing_gen_pkg.sv
// Shared types for the TFT timing generator.
// FSM state encoding and the packed RGB pixel layout.
package tft_timing_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAKE,
        ST_ACTIVE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int RGB_W = 24;

endpackage

// File: rtl/tft_timing_gen_if.sv
// Pixel-source and panel-pin bundle of the TFT timing generator.
// master: generator side; slave: pixel source / panel side.
interface tft_timing_gen_if
    import tft_timing_gen_pkg::*;
#(
    parameter int CW = 12
);
    logic             i_Begin;
    logic             i_Stop;
    logic [RGB_W-1:0] i_RGB;
    logic             o_PixReq;
    logic [CW-1:0]    o_XPx;
    logic [CW-1:0]    o_YPx;
    logic             o_FrameStart;
    logic             o_Busy;
    logic [7:0]       R;
    logic [7:0]       G;
    logic [7:0]       B;
    logic             STBYB;
    logic             HSD;
    logic             VSD;
    logic             DEN;

    modport master (
        input  i_Begin, i_Stop, i_RGB,
        output o_PixReq, o_XPx, o_YPx, o_FrameStart, o_Busy,
        output R, G, B, STBYB, HSD, VSD, DEN
    );

    modport slave (
        output i_Begin, i_Stop, i_RGB,
        input  o_PixReq, o_XPx, o_YPx, o_FrameStart, o_Busy,
        input  R, G, B, STBYB, HSD, VSD, DEN
    );

endinterface

// File: rtl/tft_timing_gen_axis_counter.sv
// One timing axis: active, front porch, sync, back porch.
// o_Wrap marks the last count of the axis while inc is high.
module tft_timing_gen_axis_counter #(
    parameter int ACT  = 800,
    parameter int FP   = 40,
    parameter int SYNC = 48,
    parameter int BP   = 40,
    parameter int CW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] o_Cnt,
    output logic          o_Wrap,
    output logic          o_Act,
    output logic          o_Sync
);
    localparam int TOT = ACT + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST    = CW'(TOT - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACT);
    localparam logic [CW-1:0] SY_FST  = CW'(ACT + FP);
    localparam logic [CW-1:0] SY_LST  = CW'(ACT + FP + SYNC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        o_Wrap = inc && (cnt_q == LAST);
        o_Act  = cnt_q < ACT_END;
        o_Sync = (cnt_q >= SY_FST) && (cnt_q <= SY_LST);
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && inc) begin
            cnt_d = o_Wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Cnt = cnt_q;

endmodule

// File: rtl/tft_timing_gen.sv
// Parametrised TFT panel timing generator with STBYB wake sequencing.
// Pixel request is combinational; panel pins are registered one clock later.
module tft_timing_gen
    import tft_timing_gen_pkg::*;
#(
    parameter int H_ACT       = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 40,
    parameter int V_ACT       = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 29,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter bit DE_ONLY     = 1'b1,
    parameter int WAKE_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    tft_timing_gen_if.master  bus
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int WW    = (WAKE_FRAMES > 0) ? $clog2(WAKE_FRAMES + 1) : 1;

    if (H_TOT > (1 << CW)) begin : g_h_too_big
        $error("tft_timing_gen: H_TOT does not fit in CW bits");
    end
    if (V_TOT > (1 << CW)) begin : g_v_too_big
        $error("tft_timing_gen: V_TOT does not fit in CW bits");
    end

    state_e        state_q, state_d;
    logic [WW-1:0] wake_q, wake_d;
    logic [CW-1:0] x_cnt, y_cnt;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;
    logic          running, cnt_clr, frame_end, wake_last, pix_req;

    logic          den_q, den_d;
    logic          stbyb_q, stbyb_d;
    logic          hsd_q, hsd_d;
    logic          vsd_q, vsd_d;
    rgb_t          rgb_q, rgb_d;

    assign running   = state_q != ST_IDLE;
    assign cnt_clr   = state_d == ST_IDLE;
    assign frame_end = v_wrap;
    assign wake_last = (WAKE_FRAMES <= 1) ? 1'b1
                     : (wake_q == WW'(WAKE_FRAMES - 1));

    tft_timing_gen_axis_counter #(
        .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h (
        .clk(i_CLK), .rst(i_Reset), .en(running), .clr(cnt_clr),
        .inc(1'b1), .o_Cnt(x_cnt), .o_Wrap(h_wrap),
        .o_Act(h_act), .o_Sync(h_sync)
    );

    tft_timing_gen_axis_counter #(
        .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v (
        .clk(i_CLK), .rst(i_Reset), .en(running), .clr(cnt_clr),
        .inc(h_wrap), .o_Cnt(y_cnt), .o_Wrap(v_wrap),
        .o_Act(v_act), .o_Sync(v_sync)
    );

    // Stop outranks Begin; a stop landing on the last frame cycle skips DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.i_Stop && bus.i_Begin) begin
                    state_d = (WAKE_FRAMES == 0) ? ST_ACTIVE : ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (bus.i_Stop) begin
                    state_d = ST_IDLE;
                end else if (frame_end && wake_last) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.i_Stop) begin
                    state_d = frame_end ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wake_d = wake_q;
        if (state_q == ST_IDLE) begin
            wake_d = '0;
        end else if (state_q == ST_WAKE && frame_end
                     && wake_q != WW'(WAKE_FRAMES)) begin
            wake_d = wake_q + WW'(1);
        end
    end

    always_comb begin
        pix_req = ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN))
                  && h_act && v_act;
        den_d   = pix_req;
        rgb_d   = pix_req ? rgb_t'(bus.i_RGB) : '0;
        stbyb_d = running;
        hsd_d   = 1'b0;
        vsd_d   = 1'b0;
        if (running) begin
            hsd_d = DE_ONLY ? 1'b1 : (h_sync ? HS_POL : ~HS_POL);
            vsd_d = DE_ONLY ? 1'b1 : (v_sync ? VS_POL : ~VS_POL);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            wake_q  <= '0;
            den_q   <= 1'b0;
            rgb_q   <= '0;
            stbyb_q <= 1'b0;
            hsd_q   <= 1'b0;
            vsd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wake_q  <= wake_d;
            den_q   <= den_d;
            rgb_q   <= rgb_d;
            stbyb_q <= stbyb_d;
            hsd_q   <= hsd_d;
            vsd_q   <= vsd_d;
        end
    end

    assign bus.o_PixReq     = pix_req;
    assign bus.o_XPx        = x_cnt;
    assign bus.o_YPx        = y_cnt;
    assign bus.o_FrameStart = (state_q == ST_ACTIVE) && (x_cnt == '0)
                              && (y_cnt == '0);
    assign bus.o_Busy       = running;
    assign bus.R            = rgb_q.r;
    assign bus.G            = rgb_q.g;
    assign bus.B            = rgb_q.b;
    assign bus.STBYB        = stbyb_q;
    assign bus.HSD          = hsd_q;
    assign bus.VSD          = vsd_q;
    assign bus.DEN          = den_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen on a 7x6 panel with one wake frame.
// A position/mode reference model predicts every output each cycle.
module tb_tft_timing_gen;
    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int CW = 4;
    localparam int WF = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int M_OFF = 0, M_WAKE = 1, M_RUN = 2, M_DRAIN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tft_timing_gen_if #(.CW(CW)) bus ();

    tft_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_ONLY(1'b0),
        .WAKE_FRAMES(WF), .CW(CW)
    ) dut (
        .i_CLK(clk),
        .i_Reset(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    int          m_mode, m_p, m_wf, rgb_mode;
    logic        e_den, e_stby, e_hsd, e_vsd;
    logic [23:0] e_rgb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_now();
        int x = m_p % HT;
        int y = m_p / HT;
        bit req = (m_mode == M_RUN || m_mode == M_DRAIN) && x < HA && y < VA;
        chk("pixreq", 32'(bus.o_PixReq), 32'(req));
        chk("xpx", 32'(bus.o_XPx), x);
        chk("ypx", 32'(bus.o_YPx), y);
        chk("fstart", 32'(bus.o_FrameStart), 32'(m_mode == M_RUN && m_p == 0));
        chk("busy", 32'(bus.o_Busy), 32'(m_mode != M_OFF));
        chk("den", 32'(bus.DEN), 32'(e_den));
        chk("rgb", 32'({bus.R, bus.G, bus.B}), 32'(e_rgb));
        chk("stbyb", 32'(bus.STBYB), 32'(e_stby));
        chk("hsd", 32'(bus.HSD), 32'(e_hsd));
        chk("vsd", 32'(bus.VSD), 32'(e_vsd));
    endtask

    task automatic step(input bit b, input bit s, input bit r);
        int x = m_p % HT;
        int y = m_p / HT;
        bit req = (m_mode == M_RUN || m_mode == M_DRAIN) && x < HA && y < VA;
        bit hs = x >= HA + HF && x < HA + HF + HS;
        bit vs = y >= VA + VF && y < VA + VF + VS;
        bit last = m_p == FT - 1;
        int old = m_mode;
        logic [23:0] rgb;
        check_now();
        rgb = rgb_mode != 0 ? 24'($urandom) : {8'(x), 8'(y), 8'hA5};
        bus.i_Begin = b;
        bus.i_Stop = s;
        bus.i_RGB = rgb;
        rst = r;
        if (r) begin
            e_den = 0; e_rgb = '0; e_stby = 0; e_hsd = 0; e_vsd = 0;
            m_mode = M_OFF; m_p = 0; m_wf = 0;
        end else begin
            e_den = req;
            e_rgb = req ? rgb : 24'h0;
            e_stby = old != M_OFF;
            e_hsd = old != M_OFF && !hs;
            e_vsd = old != M_OFF && !vs;
            case (old)
                M_OFF: if (b && !s) m_mode = (WF == 0) ? M_RUN : M_WAKE;
                M_WAKE: begin
                    if (s) m_mode = M_OFF;
                    else if (last) begin
                        m_wf++;
                        if (m_wf >= WF) m_mode = M_RUN;
                    end
                end
                M_RUN: if (s) m_mode = last ? M_OFF : M_DRAIN;
                default: if (last) m_mode = M_OFF;
            endcase
            if (old == M_OFF || m_mode == M_OFF) m_p = 0;
            else m_p = (m_p + 1) % FT;
            if (m_mode == M_OFF) m_wf = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic begin_and_latency(input string tag);
        int n = 0;
        step(1, 0, 0);
        while (bus.DEN !== 1'b1 && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        // 42-cycle wake frame, then one cycle to ACTIVE and one register stage
        chk(tag, n, 43);
    endtask

    initial begin
        int n, dn, hl, vl;
        bus.i_Begin = 0;
        bus.i_Stop = 0;
        bus.i_RGB = '0;
        rgb_mode = 0;
        m_mode = M_OFF; m_p = 0; m_wf = 0;
        e_den = 0; e_rgb = '0; e_stby = 0; e_hsd = 0; e_vsd = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        step(0, 0, 1);

        repeat (3) step(0, 0, 0);
        repeat (3) step(0, 1, 0);
        chk("idle_after_stop", 32'(bus.o_Busy), 0);

        begin_and_latency("den_latency_1");

        n = 0;
        while (bus.o_FrameStart !== 1'b1 && n < 100) begin
            step(0, 0, 0);
            n++;
        end
        chk("fstart_seen", 32'(bus.o_FrameStart), 1);
        dn = 0; hl = 0; vl = 0;
        for (int i = 0; i < FT; i++) begin
            step(0, 0, 0);
            dn += int'(bus.DEN);
            hl += int'(!bus.HSD);
            vl += int'(!bus.VSD);
        end
        chk("den_per_frame", dn, HA * VA);
        chk("hsd_low_per_frame", hl, VT);
        chk("vsd_low_per_frame", vl, HT);

        n = 0;
        while (!(m_mode == M_RUN && m_p == HT + 2) && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        chk("reach_x2y1", 32'(m_p), HT + 2);
        step(0, 1, 0);
        n = 0;
        while (m_mode != M_OFF && n < 100) begin
            step(1'($urandom_range(1)), 0, 0);
            n++;
        end
        chk("drain_len", n, FT - HT - 3);
        repeat (2) step(0, 0, 0);
        chk("drain_stbyb_off", 32'(bus.STBYB), 0);

        step(1, 1, 0);
        step(0, 0, 0);
        chk("begin_stop_idle", 32'(bus.o_Busy), 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        step(0, 1, 0);
        dn = 0;
        repeat (60) begin
            step(0, 0, 0);
            dn += int'(bus.DEN);
        end
        chk("wake_stop_no_den", dn, 0);

        step(1, 0, 0);
        n = 0;
        while (!(m_mode == M_RUN && m_p == 2 * HT + 3) && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        chk("reach_x3y2", 32'(m_p), 2 * HT + 3);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("rst_den", 32'(bus.DEN), 0);
        chk("rst_xpx", 32'(bus.o_XPx), 0);
        begin_and_latency("den_latency_2");

        rgb_mode = 1;
        repeat (3000) begin
            step($urandom_range(24) == 0, $urandom_range(59) == 0,
                 $urandom_range(699) == 0);
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
